// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared widths, defaults and FSM encoding for the UART TX arbiter
package uart_tx_arbiter_pkg;

  localparam int UART_BYTE_W     = 8;
  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  function automatic int rr_next(input int cur, input int n);
    return (cur == n - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rtl/uart_tx_arbiter_rr_arbiter.sv - combinational rotating-priority picker
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  logic [NUM_REQ-1:0]   masked;
  logic [2*NUM_REQ-1:0] dbl;

  // Low half holds requests at or above ptr, high half the full set, so the
  // lowest set bit of the pair is the first requester at or after ptr.
  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    dbl    = {req, masked};
    any    = |req;
    gnt_id = '0;
    for (int j = 2 * NUM_REQ - 1; j >= 0; j--) begin
      if (dbl[j]) gnt_id = ID_W'(j % NUM_REQ);
    end
    gnt = any ? (NUM_REQ'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin share of one UART TX byte port; UART_TX_ARB_LOCK_EN adds message lock
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy
);

  arb_state_e             state_d, state_q;
  logic [UART_BYTE_W-1:0] tx_data_d, tx_data_q;
  logic [ID_W-1:0]        grant_id_d, grant_id_q;
  logic [ID_W-1:0]        last_grant_d, last_grant_q;
  logic [ID_W-1:0]        ptr, win_id;
  logic [NUM_REQ-1:0]     eligible, win;
  logic                   win_any, accept, lock_held;
  logic [UART_BYTE_W-1:0] win_data;

`ifdef UART_TX_ARB_LOCK_EN
  logic            lock_d, lock_q;
  logic [ID_W-1:0] lock_id_d, lock_id_q;

  // A held lock narrows eligibility to its owner even when the owner is idle.
  assign eligible  = lock_q ? (req_valid & (NUM_REQ'(1) << lock_id_q)) : req_valid;
  assign lock_held = lock_q;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      lock_d    = !req_last[win_id];
      lock_id_d = win_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
  assign lock_held   = 1'b0;
`endif

  assign ptr = ID_W'(rr_next(int'(last_grant_q), NUM_REQ));

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req    (eligible),
    .ptr    (ptr),
    .gnt    (win),
    .gnt_id (win_id),
    .any    (win_any)
  );

  assign accept    = (state_q == ARB_EMPTY) && !reset && win_any;
  assign req_ready = accept ? win : '0;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_data = req_data[UART_BYTE_W*i +: UART_BYTE_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    if (state_q == ARB_EMPTY) begin
      if (accept) begin
        state_d      = ARB_FULL;
        tx_data_d    = win_data;
        grant_id_d   = win_id;
        last_grant_d = win_id;
      end
    end else if (tx_ready) begin
      state_d = ARB_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_EMPTY;
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign tx_valid = (state_q == ARB_FULL);
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = tx_valid || lock_held;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_data;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [1:0]  grant_id;
  logic        busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  int vectors = 0;
  int fails   = 0;

  logic [7:0] q_data [4][16];
  logic       q_last [4][16];
  int         q_head [4];
  int         q_cnt  [4];
  logic       cont   [4];
  logic [7:0] cont_data [4];
  logic [7:0] rx_data [64];
  logic [1:0] rx_id   [64];
  int         rx_n;
  logic [1:0] acc_id  [64];
  int         acc_n;
  int         tx_period;
  int         busy_cnt;
  logic       tx_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    q_data[r][q_cnt[r]] = d;
    q_last[r][q_cnt[r]] = l;
    q_cnt[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (cont[i]) begin
        req_valid[i] = 1'b1; req_data[8*i +: 8] = cont_data[i]; req_last[i] = 1'b1;
      end else if (q_head[i] < q_cnt[i]) begin
        req_valid[i] = 1'b1; req_data[8*i +: 8] = q_data[i][q_head[i]]; req_last[i] = q_last[i][q_head[i]];
      end else begin
        req_valid[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
      end
    end
    tx_ready = !tx_hold && (busy_cnt == 0);
  endtask

  task automatic clear_models();
    for (int i = 0; i < 4; i++) begin
      q_head[i] = 0; q_cnt[i] = 0; cont[i] = 1'b0; cont_data[i] = 8'h00;
    end
    rx_n = 0; acc_n = 0; busy_cnt = 0; tx_hold = 1'b0;
  endtask

  task automatic tick();
    logic [3:0] took;
    logic       hs;
    took = req_ready & req_valid;
    hs   = tx_valid && tx_ready;
    if (hs && rx_n < 64) begin
      rx_data[rx_n] = tx_data; rx_id[rx_n] = grant_id; rx_n++;
    end
    for (int i = 0; i < 4; i++) begin
      if (took[i]) begin
        if (acc_n < 64) begin acc_id[acc_n] = 2'(i); acc_n++; end
        if (!cont[i]) q_head[i]++;
      end
    end
    @(posedge clk); #1;
    if (hs) busy_cnt = tx_period - 1;
    else if (busy_cnt > 0) busy_cnt--;
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_models();
    drive(); #1;
    tick(); tick();
    reset = 1'b0;
    drive(); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a0, cnt77;
    logic [7:0] exp_seq [5];
    reset = 1'b1; req_data = '0; req_valid = '0; req_last = '0; tx_ready = 1'b0;
    tx_period = 20;
    clear_models();
    for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i), 1'b1);
    drive(); #1;
    tick(); tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'h00);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    reset = 1'b0; drive(); #1;
    check("t1_first_ready", 32'(req_ready), 32'b0001);
    for (int k = 0; k < 400 && rx_n < 4; k++) tick();
    check("t1_rx_count", 32'(rx_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_rx_data", 32'(rx_data[i]), 32'h10 + 32'(i));
      check("t1_rx_id",   32'(rx_id[i]),   32'(i));
    end

    tx_period = 3;
    do_reset();
    cont[2] = 1'b1; cont_data[2] = 8'h22; drive(); #1;
    for (int k = 0; k < 12; k++) tick();
    a0 = acc_n;
    push(0, 8'h05, 1'b1); drive(); #1;
    for (int k = 0; k < 100 && q_head[0] < q_cnt[0]; k++) tick();
    check("t2_r0_served", 32'(q_head[0]), 32'd1);
    check("t2_r0_next_grant", 32'(acc_id[a0]), 32'd0);
    for (int k = 0; k < 20; k++) tick();
    check("t2_r2_continues", 32'(acc_id[acc_n-1]), 32'd2);
    check("t2_r2_count", 32'(acc_n - a0 >= 3), 32'd1);

    tx_period = 1;
    do_reset();
    tx_hold = 1'b1;
    push(1, 8'h77, 1'b1); drive(); #1;
    tick();
    push(0, 8'h66, 1'b1); drive(); #1;
    for (int k = 0; k < 100; k++) begin
      check("t3_hold", {17'd0, tx_valid, tx_data, grant_id, req_ready}, {17'd0, 1'b1, 8'h77, 2'd1, 4'b0000});
      tick();
    end
    tx_hold = 1'b0; drive(); #1;
    for (int k = 0; k < 10; k++) tick();
    cnt77 = 0;
    for (int i = 0; i < rx_n; i++) if (rx_data[i] == 8'h77) cnt77++;
    check("t3_once", 32'(cnt77), 32'd1);
    check("t3_total", 32'(rx_n), 32'd2);

    tx_period = 5;
    do_reset();
    push(1, 8'hA0, 1'b0); push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b1);
    drive(); #1;
    tick();
    cont[0] = 1'b1; cont_data[0] = 8'h55; drive(); #1;
    for (int k = 0; k < 300 && rx_n < 5; k++) tick();
`ifdef UART_TX_ARB_LOCK_EN
    exp_seq[0] = 8'hA0; exp_seq[1] = 8'hA1; exp_seq[2] = 8'hA2; exp_seq[3] = 8'h55; exp_seq[4] = 8'h55;
`else
    exp_seq[0] = 8'hA0; exp_seq[1] = 8'h55; exp_seq[2] = 8'hA1; exp_seq[3] = 8'h55; exp_seq[4] = 8'hA2;
`endif
    check("t4_rx_count", 32'(rx_n >= 5), 32'd1);
    for (int i = 0; i < 5; i++) check("t4_seq", 32'(rx_data[i]), 32'(exp_seq[i]));

    tx_period = 1;
    do_reset();
    tx_hold = 1'b1;
    push(2, 8'h3C, 1'b0); push(2, 8'h3D, 1'b1); drive(); #1;
    tick(); tick(); tick();
    check("t5_full_before", {29'd0, tx_valid, grant_id}, {29'd0, 1'b1, 2'd2});
    push(0, 8'h0A, 1'b1);
    reset = 1'b1; drive(); #1;
    tick();
    check("t5_tx_valid_cleared", 32'(tx_valid), 32'd0);
    check("t5_busy_cleared", 32'(busy), 32'd0);
    reset = 1'b0; drive(); #1;
    check("t5_next_grant_r0", 32'(req_ready), 32'b0001);

    tx_period = 1;
    do_reset();
    push(3, 8'hC3, 1'b1); drive(); #1;
    check("t6_ready_same_cycle", 32'(req_ready), 32'b1000);
    tick();
    check("t6_out", {21'd0, tx_valid, tx_data, grant_id}, {21'd0, 1'b1, 8'hC3, 2'd3});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
